// File: rtl/keypad_pkg.sv
// Shared key codes, matrix geometry and per-scan result type for the keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    localparam logic [3:0] KEY_0 = 4'd0;
    localparam logic [3:0] KEY_1 = 4'd1;
    localparam logic [3:0] KEY_2 = 4'd2;
    localparam logic [3:0] KEY_3 = 4'd3;
    localparam logic [3:0] KEY_4 = 4'd4;
    localparam logic [3:0] KEY_5 = 4'd5;
    localparam logic [3:0] KEY_6 = 4'd6;
    localparam logic [3:0] KEY_7 = 4'd7;
    localparam logic [3:0] KEY_8 = 4'd8;
    localparam logic [3:0] KEY_9 = 4'd9;
    localparam logic [3:0] KEY_A = 4'd10;
    localparam logic [3:0] KEY_B = 4'd11;
    localparam logic [3:0] KEY_C = 4'd12;
    localparam logic [3:0] KEY_D = 4'd13;
    localparam logic [3:0] KEY_E = 4'd14;
    localparam logic [3:0] KEY_F = 4'd15;

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} scan_res_e;

    // Matrix position (row * NUM_COLS + col) to key code.
    function automatic logic [3:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:    key_code = KEY_1;
            4'd1:    key_code = KEY_2;
            4'd2:    key_code = KEY_3;
            4'd3:    key_code = KEY_A;
            4'd4:    key_code = KEY_4;
            4'd5:    key_code = KEY_5;
            4'd6:    key_code = KEY_6;
            4'd7:    key_code = KEY_B;
            4'd8:    key_code = KEY_7;
            4'd9:    key_code = KEY_8;
            4'd10:   key_code = KEY_9;
            4'd11:   key_code = KEY_C;
            4'd12:   key_code = KEY_0;
            4'd13:   key_code = KEY_F;
            4'd14:   key_code = KEY_E;
            default: key_code = KEY_D;
        endcase
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces per-scan results into a stable key state and emits the key strobe.
// Optional auto-repeat of the strobe is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 100
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       res_valid_i,
    input  scan_res_e  res_i,
    input  logic [3:0] code_i,
    output logic [3:0] value_o,
    output logic       strobe_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

    scan_res_e       cand_res_q, cand_res_d, stable_res_q, stable_res_d;
    logic [3:0]      cand_code_q, cand_code_d, stable_code_q, stable_code_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      value_q, value_d;
    logic            strobe_q, strobe_d;
    logic            stable_chg;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);
    logic [RepW-1:0] rep_q, rep_d;
`endif

    always_comb begin
        cand_res_d    = cand_res_q;
        cand_code_d   = cand_code_q;
        cnt_d         = cnt_q;
        stable_res_d  = stable_res_q;
        stable_code_d = stable_code_q;
        value_d       = value_q;
        strobe_d      = 1'b0;
        stable_chg    = 1'b0;
        if (res_valid_i) begin
            if (res_i == cand_res_q && code_i == cand_code_q) begin
                if (cnt_q != CntW'(DEBOUNCE_SCANS)) cnt_d = cnt_q + CntW'(1);
            end else begin
                cand_res_d  = res_i;
                cand_code_d = code_i;
                cnt_d       = CntW'(1);
            end
            // Non-key results carry code 0, so a plain code compare is exact.
            if (cnt_d == CntW'(DEBOUNCE_SCANS) && cand_res_d != RES_MULTI &&
                (cand_res_d != stable_res_q || cand_code_d != stable_code_q)) begin
                stable_res_d  = cand_res_d;
                stable_code_d = cand_code_d;
                stable_chg    = 1'b1;
                if (cand_res_d == RES_KEY) begin
                    value_d  = cand_code_d;
                    strobe_d = 1'b1;
                end
            end
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d = rep_q;
        if (stable_chg) begin
            rep_d = '0;
        end else if (res_valid_i && stable_res_q == RES_KEY) begin
            if (rep_q == RepW'(REPEAT_SCANS - 1)) begin
                rep_d    = '0;
                strobe_d = 1'b1;
            end else begin
                rep_d = rep_q + RepW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_res_q    <= RES_NONE;
            cand_code_q   <= '0;
            cnt_q         <= '0;
            stable_res_q  <= RES_NONE;
            stable_code_q <= '0;
            value_q       <= '0;
            strobe_q      <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q         <= '0;
`endif
        end else begin
            cand_res_q    <= cand_res_d;
            cand_code_q   <= cand_code_d;
            cnt_q         <= cnt_d;
            stable_res_q  <= stable_res_d;
            stable_code_q <= stable_code_d;
            value_q       <= value_d;
            strobe_q      <= strobe_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q         <= rep_d;
`endif
        end
    end

    assign value_o  = value_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 keypad row scanner: drives rows, synchronizes and samples columns, decodes each scan.
// KEYPAD_AUTOREPEAT_EN enables strobe auto-repeat inside keypad_debounce.
module keypad_scan_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 100
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] value,
    output logic       key_pressed
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {DriveR0, DriveR1, DriveR2, DriveR3} scan_st_e;

    scan_st_e    state_q;
    logic [DivW-1:0] div_q;
    logic [3:0]  row_q;
    logic [3:0]  col_meta_q, col_sync_q;
    logic [11:0] closed_q;
    logic        res_valid_q;
    scan_res_e   res_q;
    logic [3:0]  res_code_q;

    logic        last;
    logic [15:0] closed_all;
    logic [1:0]  hits;
    logic [3:0]  hit_code;
    scan_res_e   scan_res;
    logic [3:0]  scan_code;

    assign last       = (div_q == DivW'(SCAN_DIV - 1));
    // Row 3 closures come straight from the sample taken on the final dwell cycle.
    assign closed_all = {~col_sync_q, closed_q};

    always_comb begin
        hits     = 2'd0;
        hit_code = '0;
        for (int i = 0; i < NUM_ROWS * NUM_COLS; i++) begin
            if (closed_all[i]) begin
                if (hits != 2'd2) hits = hits + 2'd1;
                hit_code = key_code(4'(i));
            end
        end
        scan_res  = RES_NONE;
        scan_code = '0;
        if (hits == 2'd1) begin
            scan_res  = RES_KEY;
            scan_code = hit_code;
        end else if (hits == 2'd2) begin
            scan_res = RES_MULTI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DriveR0;
            div_q       <= '0;
            row_q       <= 4'b1110;
            col_meta_q  <= '1;
            col_sync_q  <= '1;
            closed_q    <= '0;
            res_valid_q <= 1'b0;
            res_q       <= RES_NONE;
            res_code_q  <= '0;
        end else begin
            col_meta_q  <= col;
            col_sync_q  <= col_meta_q;
            res_valid_q <= 1'b0;
            if (last) begin
                div_q <= '0;
                unique case (state_q)
                    DriveR0: begin
                        state_q        <= DriveR1;
                        row_q          <= 4'b1101;
                        closed_q[3:0]  <= ~col_sync_q;
                    end
                    DriveR1: begin
                        state_q        <= DriveR2;
                        row_q          <= 4'b1011;
                        closed_q[7:4]  <= ~col_sync_q;
                    end
                    DriveR2: begin
                        state_q        <= DriveR3;
                        row_q          <= 4'b0111;
                        closed_q[11:8] <= ~col_sync_q;
                    end
                    default: begin
                        state_q     <= DriveR0;
                        row_q       <= 4'b1110;
                        closed_q    <= '0;
                        res_valid_q <= 1'b1;
                        res_q       <= scan_res;
                        res_code_q  <= scan_code;
                    end
                endcase
            end else begin
                div_q <= div_q + DivW'(1);
            end
        end
    end

    assign row = row_q;

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .REPEAT_SCANS  (REPEAT_SCANS)
    ) u_debounce (
        .clk_i      (clk),
        .rst_i      (rst),
        .res_valid_i(res_valid_q),
        .res_i      (res_q),
        .code_i     (res_code_q),
        .value_o    (value),
        .strobe_o   (key_pressed)
    );

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Directed bench: behavioural keypad matrix, row-rotation model and strobe scoreboard.
module tb_keypad_scan_decoder;

    localparam int unsigned SD = 4;
    localparam int unsigned DS = 3;
    localparam int unsigned RS = 5;
    localparam int SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row, col, value;
    logic        key_pressed;
    logic [15:0] pressed = '0;

    int  tests = 0;
    int  fails = 0;
    int  mcnt = 0;
    bit  row_chk = 1'b0;
    bit  kp_prev = 1'b0;
    int  exp_q[$];

    keypad_scan_decoder #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DS),
        .REPEAT_SCANS  (RS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .value      (value),
        .key_pressed(key_pressed)
    );

    always #5 clk = ~clk;

    // Closed switch connects a driven-low row to its column.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) mcnt <= 0;
        else     mcnt <= mcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] exp_row;
        int e;
        if (row_chk) begin
            exp_row = 4'b1111;
            exp_row[(mcnt / SD) % 4] = 1'b0;
            check("row", {28'd0, row}, {28'd0, exp_row});
            if (key_pressed) begin
                check("strobe_gap", {31'd0, kp_prev}, 32'd0);
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_strobe: observed value %0d expected no strobe", value);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("strobe_value", {28'd0, value}, e);
                end
            end
            kp_prev = key_pressed;
        end
    end

    task automatic align();
        @(negedge clk);
        while (mcnt % SCAN != 0) @(negedge clk);
    endtask

    task automatic scans(input int n);
        repeat (n * SCAN) @(negedge clk);
    endtask

    task automatic sb_empty(input string tag);
        check(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        row_chk = 1'b1;
        check("reset_value", {28'd0, value}, 32'd0);
        check("reset_strobe", {31'd0, key_pressed}, 32'd0);

        // Idle: rows rotate, no strobe
        align();
        scans(10);
        check("idle_value", {28'd0, value}, 32'd0);

        // Key 7 (r2,c0) held 8 scans
        pressed = 16'h0100;
        exp_q.push_back(7);
        scans(4);
        sb_empty("key7_latency");
        scans(4);
        pressed = '0;
        scans(4);
        check("key7_held_value", {28'd0, value}, 32'd7);
        sb_empty("key7_single");

        // D bounce: short press, release, real press
        pressed = 16'h8000;
        scans(2);
        pressed = '0;
        scans(2);
        exp_q.push_back(13);
        pressed = 16'h8000;
        scans(4);
        pressed = '0;
        scans(4);
        sb_empty("keyD_single");
        check("keyD_value", {28'd0, value}, 32'd13);

        // 5 and 9 together, then 9 released
        pressed = 16'h0420;
        scans(6);
        check("multi_value", {28'd0, value}, 32'd13);
        exp_q.push_back(5);
        pressed = 16'h0020;
        scans(4);
        sb_empty("key5_after_multi");
        check("key5_value", {28'd0, value}, 32'd5);
        pressed = '0;
        scans(4);

        // A then B with no gap
        exp_q.push_back(10);
        pressed = 16'h0008;
        scans(4);
        sb_empty("keyA");
        exp_q.push_back(11);
        pressed = 16'h0080;
        scans(4);
        sb_empty("keyB");
        check("keyB_value", {28'd0, value}, 32'd11);
        pressed = '0;
        scans(4);

        // Mid-scan reset
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_value", {28'd0, value}, 32'd0);
        check("midreset_row", {28'd0, row}, 32'd14);
        check("midreset_strobe", {31'd0, key_pressed}, 32'd0);
        scans(4);
        sb_empty("post_reset_quiet");
        check("post_reset_value", {28'd0, value}, 32'd0);

        // Key 3 held 20 scans
        align();
        exp_q.push_back(3);
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_q.push_back(3);
        exp_q.push_back(3);
        exp_q.push_back(3);
`endif
        pressed = 16'h0004;
        scans(20);
        pressed = '0;
        scans(4);
        sb_empty("key3_repeat");
        check("key3_value", {28'd0, value}, 32'd3);

        row_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
